// File: rtl/branch_resolve_if.sv
// ALU-to-branch-resolve beat interface plus the fetch redirect handshake.
// master: the ALU/fetch side that drives beats and acks.
// slave: the branch_resolve unit.
interface branch_resolve_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] ir;
  logic [1:0]  br_op;
  logic [31:0] dr;
  logic [31:0] ind_tgt;
  logic        sf;
  logic        zf;
  logic        cf;
  logic        vf;
  logic        pf;
  logic        flag_up;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ack;
  logic [4:0]  flags_q;
  logic        squashing;

  modport master (
    output in_valid, ir, br_op, dr, ind_tgt, sf, zf, cf, vf, pf, flag_up,
           redirect_ack,
    input  in_ready, redirect_valid, redirect_pc, flags_q, squashing
  );

  modport slave (
    input  in_valid, ir, br_op, dr, ind_tgt, sf, zf, cf, vf, pf, flag_up,
           redirect_ack,
    output in_ready, redirect_valid, redirect_pc, flags_q, squashing
  );
endinterface

// File: rtl/branch_resolve.sv
// Branch resolution in the execute stage: holds the architectural flag
// register, evaluates B/Bcc/indirect branches against it, raises a redirect
// to fetch over a valid/ack handshake, then drops SQUASH_DEPTH wrong-path
// beats.
module branch_resolve #(
  parameter int SQUASH_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  branch_resolve_if.slave bus
);

  typedef enum logic [1:0] {RUN, REDIR, SQUASH} state_t;

  localparam logic [1:0] OP_B   = 2'b01;
  localparam logic [1:0] OP_BCC = 2'b10;
  localparam logic [1:0] OP_IND = 2'b11;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [4:0]  flags, flags_nxt;
  logic        rv, rv_nxt;
  logic [31:0] rpc, rpc_nxt;
  logic        accept;
  logic        taken;

  // Only the condition-code field of the instruction word matters here.
  logic unused_ir;
  assign unused_ir = ^{bus.ir[31:20], bus.ir[15:0]};

  // Condition evaluation over {sf,zf,cf,vf,pf}; odd codes invert even ones.
  function automatic logic cond_holds(input logic [3:0] cc, input logic [4:0] f);
    logic s, z, c, v, p, base;
    {s, z, c, v, p} = f;
    case (cc[3:1])
      3'd0:    base = v;
      3'd1:    base = c;
      3'd2:    base = z;
      3'd3:    base = c | z;
      3'd4:    base = s;
      3'd5:    base = p;
      3'd6:    base = s ^ v;
      default: base = z | (s ^ v);
    endcase
    return base ^ cc[0];
  endfunction

  assign bus.in_ready       = (state != REDIR);
  assign bus.squashing      = (state == SQUASH);
  assign bus.redirect_valid = rv;
  assign bus.redirect_pc    = rpc;
  assign bus.flags_q        = flags;

  assign accept = bus.in_valid & bus.in_ready;
  // The decision uses the registered flags, i.e. those from before this beat.
  assign taken  = (bus.br_op == OP_B) || (bus.br_op == OP_IND) ||
                  ((bus.br_op == OP_BCC) && cond_holds(bus.ir[19:16], flags));

  // Next-state, flag, counter and redirect computation.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    flags_nxt = flags;
    rv_nxt    = rv;
    rpc_nxt   = rpc;
    case (state)
      RUN: begin
        if (accept) begin
          if (bus.flag_up) flags_nxt = {bus.sf, bus.zf, bus.cf, bus.vf, bus.pf};
          if (taken) begin
            rpc_nxt   = (bus.br_op == OP_IND) ? bus.ind_tgt : bus.dr;
            rv_nxt    = 1'b1;
            state_nxt = REDIR;
          end
        end
      end
      REDIR: begin
        if (bus.redirect_ack) begin
          rv_nxt = 1'b0;
          if (SQUASH_DEPTH == 0) begin
            state_nxt = RUN;
          end else begin
            cnt_nxt   = 4'(SQUASH_DEPTH);
            state_nxt = SQUASH;
          end
        end
      end
      SQUASH: begin
        if (accept) begin
          cnt_nxt = cnt - 4'd1;
          if (cnt == 4'd1) state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
      flags <= '0;
      rv    <= 1'b0;
      rpc   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      flags <= flags_nxt;
      rv    <= rv_nxt;
      rpc   <= rpc_nxt;
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios plus a
// randomized run compared against a behavioural model.
module tb_branch_resolve;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  branch_resolve_if b ();
  branch_resolve_if b0 ();

  branch_resolve #(.SQUASH_DEPTH(2)) dut  (.clk(clk), .rst(rst), .bus(b));
  branch_resolve #(.SQUASH_DEPTH(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));

  // Advance one clock; outputs are then observed 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic beat(input logic fu, input logic [4:0] f, input logic [1:0] op,
                      input logic [3:0] cc, input logic [31:0] d, input logic [31:0] it);
    b.in_valid = 1'b1;
    b.flag_up  = fu;
    {b.sf, b.zf, b.cf, b.vf, b.pf} = f;
    b.br_op    = op;
    b.ir       = {12'h0, cc, 16'h0};
    b.dr       = d;
    b.ind_tgt  = it;
  endtask

  task automatic idle();
    b.in_valid = 1'b0;
    b.flag_up  = 1'b0;
    {b.sf, b.zf, b.cf, b.vf, b.pf} = 5'b0;
    b.br_op    = 2'b00;
    b.ir       = '0;
    b.dr       = '0;
    b.ind_tgt  = '0;
    b.redirect_ack = 1'b0;
  endtask

  // Ack the pending redirect, then feed the two squashed beats.
  task automatic ack_and_drain();
    idle();
    b.redirect_ack = 1'b1;
    cyc();
    b.redirect_ack = 1'b0;
    chk("ack_drops_valid", b.redirect_valid, 0);
    beat(1'b0, 5'b0, 2'b00, 4'h0, 0, 0);
    cyc();
    cyc();
    idle();
    chk("drain_done", b.squashing, 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_valid", b.redirect_valid, 0);
    chk("rst_pc", b.redirect_pc, 0);
    chk("rst_flags", b.flags_q, 0);
    chk("rst_squashing", b.squashing, 0);
    chk("rst_ready", b.in_ready, 1);
  endtask

  task automatic test_cmp_bcc();
    beat(1'b1, 5'b01000, 2'b00, 4'h0, 0, 0);
    cyc();
    chk("cmp_flags", b.flags_q, 5'b01000);
    beat(1'b0, 5'b0, 2'b10, 4'h4, 32'h0000_0103, 0);
    cyc();
    idle();
    chk("bcc_valid", b.redirect_valid, 1);
    chk("bcc_pc", b.redirect_pc, 32'h0000_0103);
    chk("bcc_ready", b.in_ready, 0);
    chk("bcc_flags", b.flags_q, 5'b01000);
    ack_and_drain();
  endtask

  task automatic test_not_taken();
    beat(1'b0, 5'b0, 2'b10, 4'h5, 32'h200, 0);
    cyc();
    idle();
    chk("nt_valid", b.redirect_valid, 0);
    chk("nt_ready", b.in_ready, 1);
    chk("nt_squash", b.squashing, 0);
  endtask

  task automatic test_b_squash();
    beat(1'b0, 5'b0, 2'b01, 4'h0, 32'h40, 0);
    cyc();
    // Beats offered during REDIR must not be accepted.
    beat(1'b1, 5'b10000, 2'b01, 4'h0, 32'h99, 0);
    for (int i = 0; i < 4; i++) begin
      chk("b_valid_hold", b.redirect_valid, 1);
      chk("b_ready_low", b.in_ready, 0);
      chk("b_pc_hold", b.redirect_pc, 32'h40);
      b.redirect_ack = (i == 3);
      cyc();
    end
    b.redirect_ack = 1'b0;
    chk("b_valid_after_ack", b.redirect_valid, 0);
    chk("b_ready_after_ack", b.in_ready, 1);
    chk("b_squash_on", b.squashing, 1);
    chk("b_flags_kept", b.flags_q, 5'b01000);
    beat(1'b1, 5'b10000, 2'b00, 4'h0, 0, 0);
    cyc();
    chk("sq1_flags", b.flags_q, 5'b01000);
    chk("sq1_squashing", b.squashing, 1);
    cyc();
    chk("sq2_flags", b.flags_q, 5'b01000);
    chk("sq2_squashing", b.squashing, 0);
    cyc();
    idle();
    chk("post_sq_flags", b.flags_q, 5'b10000);
    chk("post_sq_valid", b.redirect_valid, 0);
  endtask

  task automatic test_signed();
    beat(1'b1, 5'b10000, 2'b00, 4'h0, 0, 0);
    cyc();
    beat(1'b0, 5'b0, 2'b10, 4'hC, 32'h44, 0);
    cyc();
    idle();
    chk("lt_taken", b.redirect_valid, 1);
    ack_and_drain();
    beat(1'b1, 5'b10010, 2'b00, 4'h0, 0, 0);
    cyc();
    beat(1'b0, 5'b0, 2'b10, 4'hF, 32'h48, 0);
    cyc();
    idle();
    chk("gt_taken", b.redirect_valid, 1);
    chk("gt_pc", b.redirect_pc, 32'h48);
    ack_and_drain();
    beat(1'b0, 5'b0, 2'b10, 4'hE, 32'h4C, 0);
    cyc();
    idle();
    chk("le_not_taken", b.redirect_valid, 0);
  endtask

  task automatic test_indirect();
    beat(1'b0, 5'b0, 2'b11, 4'h3, 32'h10, 32'hDEAD_BEEC);
    cyc();
    idle();
    chk("ind_valid", b.redirect_valid, 1);
    chk("ind_pc", b.redirect_pc, 32'hDEAD_BEEC);
    ack_and_drain();
  endtask

  task automatic test_reset_mid_redir();
    beat(1'b1, 5'b11111, 2'b01, 4'h0, 32'h80, 0);
    cyc();
    idle();
    chk("mr_flags_and_branch", b.flags_q, 5'b11111);
    cyc();
    chk("mr_second_cycle", b.redirect_valid, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mr_valid", b.redirect_valid, 0);
    chk("mr_flags", b.flags_q, 0);
    chk("mr_ready", b.in_ready, 1);
  endtask

  task automatic test_depth0();
    logic seen;
    seen = 1'b0;
    b0.in_valid = 1'b1;
    b0.br_op    = 2'b01;
    b0.dr       = 32'h60;
    cyc();
    b0.in_valid = 1'b0;
    chk("d0_valid", b0.redirect_valid, 1);
    b0.redirect_ack = 1'b1;
    seen = seen | b0.squashing;
    cyc();
    b0.redirect_ack = 1'b0;
    seen = seen | b0.squashing;
    chk("d0_valid_low", b0.redirect_valid, 0);
    chk("d0_ready", b0.in_ready, 1);
    b0.in_valid = 1'b1;
    b0.br_op    = 2'b00;
    b0.flag_up  = 1'b1;
    b0.pf       = 1'b1;
    cyc();
    seen = seen | b0.squashing;
    b0.in_valid = 1'b0;
    b0.flag_up  = 1'b0;
    chk("d0_flags_immediate", b0.flags_q, 5'b00001);
    chk("d0_never_squash", seen, 0);
  endtask

  // Reference condition table written out code by code.
  function automatic logic ref_cond(input logic [3:0] cc, input logic [4:0] f);
    logic s, z, c, v, p;
    {s, z, c, v, p} = f;
    case (cc)
      4'h0: return v;
      4'h1: return !v;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return z;
      4'h5: return !z;
      4'h6: return c || z;
      4'h7: return !(c || z);
      4'h8: return s;
      4'h9: return !s;
      4'hA: return p;
      4'hB: return !p;
      4'hC: return s != v;
      4'hD: return s == v;
      4'hE: return z || (s != v);
      default: return !(z || (s != v));
    endcase
  endfunction

  task automatic test_random();
    logic [4:0]  m_flags;
    logic        m_pending;
    logic [31:0] m_pc;
    int          m_left;
    logic [3:0]  cc;
    logic        take;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    m_flags = '0; m_pending = 1'b0; m_pc = '0; m_left = 0;
    for (int n = 0; n < 600; n++) begin
      checks++;
      if (b.redirect_valid !== m_pending || b.redirect_pc !== m_pc ||
          b.flags_q !== m_flags || b.squashing !== (m_left > 0) ||
          b.in_ready !== !m_pending) begin
        errors++;
        $display("FAIL rand cycle %0d: got v=%b pc=%h f=%b sq=%b rdy=%b expected v=%b pc=%h f=%b sq=%b rdy=%b",
                 n, b.redirect_valid, b.redirect_pc, b.flags_q, b.squashing, b.in_ready,
                 m_pending, m_pc, m_flags, (m_left > 0), !m_pending);
      end
      cc = 4'($urandom_range(15));
      beat(1'($urandom), 5'($urandom), 2'($urandom), cc, $urandom, $urandom);
      b.in_valid     = ($urandom_range(3) != 0);
      b.ir           = {12'($urandom), cc, 16'($urandom)};
      b.redirect_ack = ($urandom_range(2) == 0);
      if (m_pending) begin
        if (b.redirect_ack) begin
          m_pending = 1'b0;
          m_left    = 2;
        end
      end else if (b.in_valid) begin
        if (m_left > 0) begin
          m_left--;
        end else begin
          take = (b.br_op == 2'b01) || (b.br_op == 2'b11) ||
                 (b.br_op == 2'b10 && ref_cond(cc, m_flags));
          if (b.flag_up) m_flags = {b.sf, b.zf, b.cf, b.vf, b.pf};
          if (take) begin
            m_pending = 1'b1;
            m_pc      = (b.br_op == 2'b11) ? b.ind_tgt : b.dr;
          end
        end
      end
      cyc();
    end
    idle();
  endtask

  initial begin
    idle();
    b0.in_valid = 1'b0; b0.ir = '0; b0.br_op = 2'b00; b0.dr = '0; b0.ind_tgt = '0;
    b0.sf = 1'b0; b0.zf = 1'b0; b0.cf = 1'b0; b0.vf = 1'b0; b0.pf = 1'b0;
    b0.flag_up = 1'b0; b0.redirect_ack = 1'b0;
    #2;
    test_reset();
    test_cmp_bcc();
    test_not_taken();
    test_b_squash();
    test_signed();
    test_indirect();
    test_reset_mid_redir();
    test_depth0();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Consumer of the ALU flag/result interface: it holds the architectural flag register, latching `sf`/`zf`/`cf`/`vf`/`pf` on every accepted beat with `flag_up`. It evaluates B/Bcc/indirect-jump conditions against that register and issues a redirect to fetch over a valid/ack handshake. After each redirect it squashes a fixed number of wrong-path beats. It sits directly after the ALU in the execute stage.

## Interface
- `SQUASH_DEPTH`, default 2: number of accepted beats discarded after each redirect is acked. Legal range 0..15.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  ALU beat valid.
- `in_ready`  out  1  beat accepted when `in_valid & in_ready`.
- `ir`  in  32  instruction word; condition code is `ir[19:16]`.
- `br_op`  in  2  branch type: 00 none, 01 B (unconditional), 10 Bcc, 11 indirect (JR/JALR/RET).
- `dr`  in  32  ALU result; branch target for B/Bcc.
- `ind_tgt`  in  32  branch target for indirect branches.
- `sf`, `zf`, `cf`, `vf`, `pf`  in  1 each  ALU flags.
- `flag_up`  in  1  the beat updates the flag register.
- `redirect_valid`  out  1  redirect request to fetch.
- `redirect_pc`  out  32  redirect target; stable while `redirect_valid` is high.
- `redirect_ack`  in  1  fetch accepts the redirect.
- `flags_q`  out  5  flag register `{sf,zf,cf,vf,pf}`.
- `squashing`  out  1  high in SQUASH.

## Operation
- States: RUN, REDIR, SQUASH. A 4-bit counter `cnt` tracks squashed beats.
- `in_ready` is 1 in RUN and SQUASH, and 0 in REDIR.
- **RUN, accepted beat:**
  - If `flag_up`: `flags_q <= {sf,zf,cf,vf,pf}`.
  - The branch decision always uses the `flags_q` value from before this beat.
  - Taken if: `br_op`=01; or `br_op`=11; or `br_op`=10 and the condition holds.
  - On taken: `redirect_pc <= (br_op==11) ? ind_tgt : dr`; `redirect_valid <= 1`; go to REDIR.
  - Not taken: no other effect.
- **Condition codes (`ir[19:16]`):**
  - 0 vf; 1 !vf
  - 2 cf; 3 !cf
  - 4 zf; 5 !zf
  - 6 cf|zf; 7 !(cf|zf)
  - 8 sf; 9 !sf
  - A pf; B !pf
  - C sf^vf; D !(sf^vf)
  - E zf|(sf^vf); F !(zf|(sf^vf))
- **REDIR:** hold `redirect_valid` and `redirect_pc`. On `redirect_ack`:
  - If `SQUASH_DEPTH`=0: go to RUN.
  - Otherwise: `cnt <= SQUASH_DEPTH` and go to SQUASH.
- **SQUASH, accepted beat:** no flag update, no branch evaluation, `cnt <= cnt-1`. When the beat is accepted with `cnt`=1, go to RUN. Non-accepted cycles do not change `cnt`.
- `redirect_ack` outside REDIR is ignored.

## Timing
- Reset values: `redirect_valid`=0, `redirect_pc`=0, `flags_q`=0, `squashing`=0, state RUN, `cnt`=0. In RUN after reset, `in_ready`=1.
- Flag latency: flags from a beat accepted in cycle N are visible on `flags_q` in N+1. A Bcc accepted in N+1 uses them, so CMP followed by Bcc needs no stall.
- Redirect latency: a taken branch accepted in cycle N raises `redirect_valid` in N+1. `in_ready` drops in N+1.
- Handshake:
  - `redirect_valid` stays high until `redirect_ack` is sampled high.
  - It is low in the cycle after the ack.
  - `in_ready` returns high in that same cycle.
  - A same-cycle ack, i.e. ack in the first cycle `redirect_valid` is high, is legal and gives a 1-cycle pulse.
- The first SQUASH beat can be accepted in the cycle after the ack.
- A beat with both `flag_up` and a taken branch in RUN does both: updates flags and redirects.
- Reset mid-REDIR or mid-SQUASH: the next cycle is RUN with reset values. A pending redirect is dropped.

## Test plan
- `flags_q`=0. Beat 1: `flag_up`=1, `zf`=1. Beat 2, next cycle: `br_op`=10, cc=4, `dr`=0x0000_0103. Response: `redirect_valid`=1 and `redirect_pc`=0x0000_0103 one cycle after beat 2; `flags_q`=5'b01000.
- With `zf`=1 latched: Bcc cc=5 -> no redirect, `in_ready` stays 1, state remains RUN.
- Taken B with `dr`=0x40 and ack held low 3 cycles:
  - `redirect_valid` high for 4 cycles; `in_ready`=0 throughout.
  - After the ack, 2 beats with `flag_up`=1 and `sf`=1 leave `flags_q` unchanged and `squashing`=1.
  - A 3rd such beat sets `flags_q[4]`=1.
- Signed conditions:
  - Latch `sf`=1, `vf`=0; Bcc cc=C -> taken.
  - Latch `sf`=1, `vf`=1, `zf`=0; cc=F -> taken; cc=E -> not taken.
- Indirect: `br_op`=11, `ind_tgt`=0xDEAD_BEEC, `dr`=0x10 -> `redirect_pc`=0xDEAD_BEEC.
- `rst` asserted in the 2nd REDIR cycle -> next cycle `redirect_valid`=0, `flags_q`=0, `in_ready`=1. With `SQUASH_DEPTH`=0, an ack returns straight to RUN with `squashing` never high.
